// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
// ---------------------------------------------------------------------------
// Load/store initiator for a word-wide data memory. The unit takes one
// byte/halfword/word request at a time. It presents the word index on the
// memory read and write address ports and returns the selected, extended
// load lane. Sub-word stores are read-modify-write because the memory only
// writes whole words.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses complete with resp_error=1.
//   undefined : the low address bits that would be misaligned are ignored.
//               H uses addr[1] as its lane and W uses the whole word.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   req_valid/req_ready request handshake (see below)
//   req_write           1 = store, 0 = load
//   req_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr            byte address
//   req_wdata           store data (low bits used for B/H)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors), held
//   resp_error          illegal funct3 / misalignment, held
//   mem_read_address    word index to memory
//   mem_write_address   word index to memory
//   mem_data_write      full word to write
//   mem_write_enabled   write strobe, high only while in STORE
//   mem_data_out        read word from memory
//   dbg_state           current FSM state, for observation only
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE. All request fields are latched on that edge,
// so later changes to the request inputs are ignored until the next transfer.
// ---------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic [XLEN-1:0] mem_read_address,
  output logic [XLEN-1:0] mem_write_address,
  output logic [XLEN-1:0] mem_data_write,
  output logic            mem_write_enabled,
  input  logic [XLEN-1:0] mem_data_out,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_RMW_WAIT  = 3'd2,
    S_STORE     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_ready;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_word_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [XLEN-1:0]   r_resp_rdata;
  logic              r_resp_error;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [15:0]       r_wdata_lo;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_error;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;
  logic [XLEN-1:0]   w_merged;

  // r_ready is high exactly in IDLE outside reset, so an accept implies IDLE.
  assign w_accept = req_valid && r_ready;

  // Request classification on the live inputs; only used on the accept edge.
  // BU/HU are load-only encodings.
  assign w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) ||
                     (req_write && (req_funct3[2:1] == 2'b10));

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_error = w_illegal || w_misaligned;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_error) begin
            w_next_state = S_DONE;
          end else if (!req_write) begin
            w_next_state = S_LOAD_WAIT;
          end else if (req_funct3 == 3'b010) begin
            w_next_state = S_STORE;
          end else begin
            w_next_state = S_RMW_WAIT;
          end
        end
      end
      S_LOAD_WAIT: w_next_state = S_DONE;
      S_RMW_WAIT:  w_next_state = S_STORE;
      S_STORE:     w_next_state = S_DONE;
      S_DONE:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // ---------------- Load lane select and extension ----------------
  // Lanes are little-endian. For halfwords, only addr[1] selects the lane.
  // When misalignment is not trapped, this also gives the "treat addr[0] as 0"
  // behaviour for free.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr_lo)
      2'd0: w_byte = mem_data_out[7:0];
      2'd1: w_byte = mem_data_out[15:8];
      2'd2: w_byte = mem_data_out[23:16];
      2'd3: w_byte = mem_data_out[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr_lo[1] ? mem_data_out[31:16] : mem_data_out[15:0];

    w_load_data = '0;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b010:  w_load_data = mem_data_out;
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = '0;
    endcase
  end

  // ---------------- Store merge ----------------
  // Only SB/SH reach RMW_WAIT. Replace the addressed lane in the word just read.
  always_comb begin
    w_merged = mem_data_out;
    if (r_funct3[1:0] == 2'b00) begin
      w_merged[{r_addr_lo, 3'b000} +: 8] = r_wdata_lo[7:0];
    end else begin
      w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata_lo;
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_word_addr  <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_wdata_lo   <= 16'h0000;
    end else begin
      // Both registered from the next state so they line up with the state.
      r_ready  <= (w_next_state == S_IDLE);
      r_mem_we <= (w_next_state == S_STORE);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word_addr <= {2'b00, req_addr[XLEN-1:2]};
            r_funct3    <= req_funct3;
            r_addr_lo   <= req_addr[1:0];
            r_wdata_lo  <= req_wdata[15:0];
            if (w_error) begin
              r_resp_rdata <= '0;
              r_resp_error <= 1'b1;
            end else if (req_write && (req_funct3 == 3'b010)) begin
              r_mem_wdata <= req_wdata;
            end
          end
        end
        S_LOAD_WAIT: begin
          r_resp_rdata <= w_load_data;
          r_resp_error <= 1'b0;
        end
        S_RMW_WAIT: begin
          r_mem_wdata <= w_merged;
        end
        S_STORE: begin
          r_resp_rdata <= '0;
          r_resp_error <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready         = r_ready;
  assign resp_valid        = (r_state == S_DONE);
  assign resp_rdata        = r_resp_rdata;
  assign resp_error        = r_resp_error;
  assign mem_read_address  = r_word_addr;
  assign mem_write_address = r_word_addr;
  assign mem_data_write    = r_mem_wdata;
  assign mem_write_enabled = r_mem_we;
  assign dbg_state         = r_state;

endmodule
